// File: rtl/alu_iter.sv
// Multi-cycle ALU: single-cycle RV32I-style ops plus iterative shift-add multiply
// and restoring divide, with valid/ready handshakes on both sides.
module alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             oVerflow,
    output logic             Carry,
    output logic             Negative,
    output logic             Zero,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [63:0] ILLEGAL = 64'hDEADBEEF_DEADBEEF;

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [3:0]       op;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             neg_q;
    logic             neg_r;

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   add_full;
    logic             add_ovf;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c;
    logic             sc_v;
    logic             sc_illegal;

    logic             is_mul_in;
    logic             is_div_in;
    logic             signed_div_in;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == CALC);

    // SUB shares the adder as A + ~B + 1 so Carry means "no borrow"
    assign is_sub   = (ALUControl == 4'b0001);
    assign b_eff    = is_sub ? ~B : B;
    assign add_full = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    assign add_ovf  = (A[WIDTH-1] == b_eff[WIDTH-1]) && (add_full[WIDTH-1] != A[WIDTH-1]);

    assign is_mul_in     = (ALUControl[3:1] == 3'b100);
    assign is_div_in     = (ALUControl[3:2] == 2'b11);
    assign signed_div_in = ALUControl[1];
    assign a_abs         = (signed_div_in && A[WIDTH-1]) ? -A : A;
    assign b_abs         = (signed_div_in && B[WIDTH-1]) ? -B : B;

    always_comb begin
        sc_res     = '0;
        sc_c       = 1'b0;
        sc_v       = 1'b0;
        sc_illegal = 1'b0;
        case (ALUControl)
            4'b0000, 4'b0001: begin
                sc_res = add_full[WIDTH-1:0];
                sc_c   = add_full[WIDTH];
                sc_v   = add_ovf;
            end
            4'b0010: sc_res = A & B;
            4'b0011: sc_res = A | B;
            4'b0100: sc_res = A ^ B;
            4'b0101: sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            4'b0110: sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
            default: begin
                sc_res     = ILLEGAL[WIDTH-1:0];
                sc_illegal = 1'b1;
            end
        endcase
    end

    // One iteration step: {hi,lo} is the product accumulator or {remainder,dividend/quotient}
    logic             op_div;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;
    logic [WIDTH-1:0] final_res;

    assign op_div = op[2];

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        div_trial = {hi, lo[WIDTH-1]};
        div_diff  = div_trial - {1'b0, mcand};
        div_ge    = (div_trial >= {1'b0, mcand});
        if (op_div) begin
            hi_next = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], div_ge};
        end else begin
            hi_next = mul_sum[WIDTH:1];
            lo_next = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end

    // Signed division fix-up; a zero divisor always yields an all-ones quotient
    always_comb begin
        final_res = '0;
        if (op_div) begin
            case (op[1:0])
                2'b00:   final_res = lo_next;
                2'b01:   final_res = hi_next;
                2'b10:   final_res = (mcand == '0) ? '1 : (neg_q ? -lo_next : lo_next);
                default: final_res = neg_r ? -hi_next : hi_next;
            endcase
        end else begin
            final_res = op[0] ? hi_next : lo_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            op       <= '0;
            mcand    <= '0;
            hi       <= '0;
            lo       <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            Result   <= '0;
            oVerflow <= 1'b0;
            Carry    <= 1'b0;
            Negative <= 1'b0;
            Zero     <= 1'b0;
        end else if (flush) begin
            state    <= IDLE;
            count    <= '0;
            Result   <= '0;
            oVerflow <= 1'b0;
            Carry    <= 1'b0;
            Negative <= 1'b0;
            Zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op    <= ALUControl;
                        count <= '0;
                        if (is_mul_in) begin
                            hi    <= '0;
                            lo    <= B;
                            mcand <= A;
                            state <= CALC;
                        end else if (is_div_in) begin
                            hi    <= '0;
                            lo    <= a_abs;
                            mcand <= b_abs;
                            neg_q <= signed_div_in && (A[WIDTH-1] ^ B[WIDTH-1]);
                            neg_r <= signed_div_in && A[WIDTH-1];
                            state <= CALC;
                        end else begin
                            Result   <= sc_res;
                            Carry    <= sc_c;
                            oVerflow <= sc_v;
                            Negative <= !sc_illegal && sc_res[WIDTH-1];
                            Zero     <= (sc_res == '0);
                            state    <= DONE;
                        end
                    end
                end
                CALC: begin
                    hi    <= hi_next;
                    lo    <= lo_next;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        Result   <= final_res;
                        Carry    <= 1'b0;
                        oVerflow <= 1'b0;
                        Negative <= final_res[WIDTH-1];
                        Zero     <= (final_res == '0);
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
